// File: rtl/dmem_stage_pkg.sv
// Shared types and constants for the data-memory access stage.
//   state_e : access FSM states
//   BE_W    : byte-enable width for a given data width
//   CNT_W   : width of the latency down-counter
package dmem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int unsigned CNT_W = 4;

  function automatic int unsigned BE_W(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM with byte-write enables and one-cycle read.
//   clk   : clock
//   en    : access enable
//   we    : 1 = byte-masked write, 0 = read
//   be    : byte enables, bit i covers wdata[8i+7:8i]
//   addr  : word address
//   wdata : write data
//   rdata : registered read data; holds its value on writes and idle cycles
module dmem_ram
  import dmem_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned BEW   = BE_W(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < int'(BEW); i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_stage.sv
// Data-memory access stage: accepts one load/store, holds stall for LATENCY
// cycles, then performs the RAM access and returns load data to the MEM/WB
// buffer.
//   clk, rst    : clock, synchronous active-high reset
//   flush       : pipeline flush, aborts a presented or in-flight request
//   req_*       : request from EX/MEM (valid, we, addr, wdata, be)
//   stall       : combinational hold to upstream
//   resp_valid  : one-cycle pulse when data_out carries new load data
//   data_out    : load data, drives the buffer's data_in
module dmem_stage
  import dmem_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    req_valid,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    stall,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   data_out
);

  localparam int unsigned BEW = BE_W(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BEW-1:0]        be_q, be_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  rd_seen_q, rd_seen_d;
  logic                  ram_en;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Next-state, request capture and RAM strobe.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    resp_valid_d = 1'b0;
    rd_seen_d    = rd_seen_q;
    ram_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Reset must also suppress the write so an in-flight store is dropped.
          ram_en       = !rst;
          state_d      = IDLE;
          resp_valid_d = !we_q;
          if (!we_q) rd_seen_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      resp_valid_q <= 1'b0;
      rd_seen_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      resp_valid_q <= resp_valid_d;
      rd_seen_q    <= rd_seen_d;
    end
  end

  dmem_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (we_q),
    .be   (be_q),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  // Nothing is accepted while reset is applied, so stall stays low then too.
  assign stall = !rst && !flush &&
                 (((state_q == IDLE) && req_valid) ||
                  ((state_q == BUSY) && (cnt_q != '0)));

  assign resp_valid = resp_valid_q;

  // The RAM read register has no reset; mask it until a load has completed
  // since the last reset so data_out reads as zero out of reset.
  assign data_out = rd_seen_q ? ram_rdata : '0;

endmodule

// File: doc/dmem_stage.md
Name: dmem_stage

Overview:
- Data-memory access stage of the pipeline.
- Sits directly upstream of the MEM/WB buffer memory and drives that buffer's data_in.
- Accepts one load or store per request from the EX/MEM side, performs the access with a fixed multi-cycle latency, and stalls upstream while busy.
- Honours the same pipeline flush signal as the buffer.

Parameters:
- DATA_WIDTH, 64, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, word-address width; depth = 2**ADDR_WIDTH words.
- LATENCY, 2, number of cycles stall is held per accepted request; legal range 1..15.

Ports:
- clk  input  1  pipeline clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush; aborts an in-flight or presented request.
- req_valid  input  1  request present; held stable by upstream while stall=1.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_WIDTH  word address.
- req_wdata  input  DATA_WIDTH  store data.
- req_be  input  DATA_WIDTH/8  store byte enables; bit i covers bits [8i+7:8i].
- stall  output  1  combinational; upstream must hold its request and its pipeline registers.
- resp_valid  output  1  registered; one-cycle pulse when load data is valid.
- data_out  output  DATA_WIDTH  registered load data; feeds the downstream buffer's data_in.

Behaviour:
- Reset (rst=1 at an edge):
  - state becomes IDLE, cnt=0, resp_valid=0, data_out=0.
  - Any in-flight store is discarded (no RAM write).
  - RAM contents are not cleared.
  - rst has priority over flush and over requests.
- States:
  - IDLE:
    - If req_valid=1 and flush=0, latch we/addr/wdata/be, set cnt=LATENCY-1 and go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY, cnt!=0: decrement cnt.
  - BUSY, cnt==0: perform the access at this edge and go to IDLE.
    - Load: data_out <= mem[addr], resp_valid <= 1.
    - Store: write bytes of mem[addr] where be[i]=1; resp_valid <= 0; data_out unchanged.
- stall = ~flush & ((IDLE & req_valid) | (BUSY & cnt!=0)).
  - stall is high for exactly LATENCY cycles per request.
  - stall drops in the completing cycle, so upstream advances on the same edge that registers the response.
- Timing:
  - Load presented in cycle 0 gives resp_valid=1 in cycle LATENCY+1.
  - Back-to-back requests: the next request is presented in cycle LATENCY+1 and is accepted immediately.
  - Throughput is one request per LATENCY+1 cycles.
- resp_valid is high for exactly one cycle per completed load and is 0 in all other cycles.
- Flush:
  - Flush in BUSY (any cnt): go to IDLE with no RAM write; resp_valid=0 next cycle; data_out unchanged.
  - Flush in IDLE with req_valid=1: the request is not accepted and stall=0.
- Read-after-write: a load issued after a store to the same address returns the merged store data. The store has completed before the load is accepted, so no bypass is needed.
- Zero byte enables on a store: full latency is still spent and memory is unchanged.
- Address range: every ADDR_WIDTH value is valid; there is no wrap or out-of-range handling.

Decomposition:
- Shared package contents:
  - state enum {IDLE, BUSY}.
  - Function BE_W(DATA_WIDTH) = DATA_WIDTH/8.
  - Counter width constant CNT_W = 4.
- One sub-module: dmem_ram.
  - Single-port synchronous RAM with byte-write enables.
  - Ports: clk, en, we, be, addr, wdata, rdata; one-cycle read.
  - The dmem_stage FSM asserts en only in the completing BUSY cycle.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req_valid=1 -> stall=0 throughout, resp_valid=0, data_out=0; state is IDLE after release.
- Store then load, LATENCY=2:
  - Store addr 5, wdata 20, be=FF -> stall high 2 cycles, no resp_valid.
  - Load addr 5 -> resp_valid pulses 3 cycles after presentation with data_out=20.
- Byte-enable merge:
  - Store addr 7 = 0x1111_1111_1111_1111, be=FF.
  - Store addr 7 = 0x0000_0000_0000_2222, be=03.
  - Load addr 7 -> data_out=0x1111_1111_1111_2222.
- Back-to-back loads of addr 5 (22) and addr 6 (50), written beforehand -> resp_valid pulses 3 cycles apart with data_out 22 then 50; stall low for exactly one cycle between them.
- Flush mid-store: store addr 9 = 99, flush=1 in the first BUSY cycle -> stall=0; a later load of addr 9 returns its prior value (0 after an initial write of 0).
- Reset mid-load: rst=1 during BUSY -> resp_valid never pulses, data_out=0; the next load after release completes normally with correct data.
